// File: rtl/imem_boot_ctrl_if.sv
// Purpose: groups the loader, core-fetch and memory-side signals of the
//          instruction-memory boot controller into one bundle.
// Ports (signals):
//   ld_valid/ld_ready/ld_data/ld_last       loader stream into the controller
//   fetch_req/fetch_addr                    core fetch request (byte address)
//   fetch_valid/fetch_rdata/fetch_fault     fetch response, 1-cycle latency
//   mem_we/mem_addr/mem_wdata/mem_rdata     single-port synchronous memory
// Modports: slave = the controller, master = its environment.
interface imem_boot_ctrl_if #(
   parameter int unsigned ADDR_W = 10
);
   logic              ld_valid;
   logic              ld_ready;
   logic [31:0]       ld_data;
   logic              ld_last;

   logic              fetch_req;
   logic [31:0]       fetch_addr;
   logic              fetch_valid;
   logic [31:0]       fetch_rdata;
   logic              fetch_fault;

   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata;

   modport slave (
      input  ld_valid, ld_data, ld_last,
      input  fetch_req, fetch_addr,
      input  mem_rdata,
      output ld_ready,
      output fetch_valid, fetch_rdata, fetch_fault,
      output mem_we, mem_addr, mem_wdata
   );

   modport master (
      output ld_valid, ld_data, ld_last,
      output fetch_req, fetch_addr,
      output mem_rdata,
      input  ld_ready,
      input  fetch_valid, fetch_rdata, fetch_fault,
      input  mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/imem_boot_ctrl.sv
// Purpose: owns a single-port instruction memory; after reset it streams a
//          program image from the loader into memory, then releases the core
//          and serves its fetches. Loader writes and fetches never share a cycle.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   bus          imem_boot_ctrl_if.slave (loader, fetch, memory signals)
//   core_rst     holds the core in reset until the image is loaded
//   boot_done    image loaded, core running
//   boot_err     image overflowed the memory; sticky until rst
//   boot_words   number of words written by the current load
module imem_boot_ctrl #(
   parameter int unsigned ADDR_W = 10,
   parameter int unsigned DEPTH  = 1024
) (
   input  logic              clk,
   input  logic              rst,
   imem_boot_ctrl_if.slave   bus,
   output logic              core_rst,
   output logic              boot_done,
   output logic              boot_err,
   output logic [ADDR_W:0]   boot_words
);

   localparam logic [1:0] ST_LOAD  = 2'd0;
   localparam logic [1:0] ST_FLUSH = 2'd1;
   localparam logic [1:0] ST_RUN   = 2'd2;
   localparam logic [1:0] ST_ERROR = 2'd3;

   localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

   logic [1:0]        state;
   logic [1:0]        state_nxt;
   logic [ADDR_W-1:0] wr_ptr;
   logic              accept;
   logic              fetch_go;
   logic              fetch_bad;
   logic              ready_c;
   logic              we_c;
   logic [ADDR_W-1:0] addr_c;
   logic              resp_valid;
   logic              resp_fault;
   logic [31:0]       rdata_hold;
   logic [31:0]       rdata_c;

   // Misaligned or beyond the memory's byte range
   assign fetch_bad = (bus.fetch_addr[1:0] != 2'b00) ||
                      (bus.fetch_addr[31:ADDR_W+2] != '0);

   // Next state and memory-port steering
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      fetch_go  = 1'b0;
      ready_c   = 1'b0;
      we_c      = 1'b0;
      addr_c    = wr_ptr;
      case (state)
         ST_LOAD: begin
            ready_c = 1'b1;
            if (bus.ld_valid) begin
               accept = 1'b1;
               we_c   = 1'b1;
               if (bus.ld_last) begin
                  state_nxt = ST_FLUSH;
               end else if (wr_ptr == LAST_PTR) begin
                  state_nxt = ST_ERROR;
               end
            end
         end
         ST_FLUSH: state_nxt = ST_RUN;
         ST_RUN: begin
            if (bus.fetch_req) begin
               fetch_go = 1'b1;
               addr_c   = bus.fetch_addr[ADDR_W+1:2];
            end
         end
         ST_ERROR: state_nxt = ST_ERROR;
         default:  state_nxt = ST_LOAD;
      endcase
   end

   assign bus.ld_ready  = ready_c;
   assign bus.mem_we    = we_c;
   assign bus.mem_addr  = addr_c;
   assign bus.mem_wdata = bus.ld_data;

   // Memory read data arrives in the response cycle, so it is muxed straight
   // through; the hold register keeps the last response between requests.
   always_comb begin
      rdata_c = rdata_hold;
      if (resp_valid) begin
         rdata_c = resp_fault ? 32'h0 : bus.mem_rdata;
      end
   end

   assign bus.fetch_valid = resp_valid;
   assign bus.fetch_fault = resp_fault;
   assign bus.fetch_rdata = rdata_c;

   // State, load pointer, status flags and fetch response pipeline
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_LOAD;
         wr_ptr     <= '0;
         boot_words <= '0;
         core_rst   <= 1'b1;
         boot_done  <= 1'b0;
         boot_err   <= 1'b0;
         resp_valid <= 1'b0;
         resp_fault <= 1'b0;
         rdata_hold <= 32'h0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            wr_ptr     <= wr_ptr + ADDR_W'(1);
            boot_words <= boot_words + (ADDR_W+1)'(1);
         end
         core_rst   <= (state_nxt != ST_RUN);
         boot_done  <= (state_nxt == ST_RUN);
         boot_err   <= (state_nxt == ST_ERROR);
         resp_valid <= fetch_go;
         resp_fault <= fetch_go & fetch_bad;
         if (resp_valid) begin
            rdata_hold <= rdata_c;
         end
      end
   end

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Purpose: self-checking bench for imem_boot_ctrl with an external memory
//          model, a fetch vector table, directed boot sequences and a
//          randomized load/fetch phase checked against an array model.
module tb_imem_boot_ctrl;
   localparam int unsigned ADDR_W = 10;
   localparam int unsigned DEPTH  = 1024;

   logic              clk = 1'b0;
   logic              rst;
   logic              core_rst;
   logic              boot_done;
   logic              boot_err;
   logic [ADDR_W:0]   boot_words;

   imem_boot_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

   imem_boot_ctrl #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .core_rst   (core_rst),
      .boot_done  (boot_done),
      .boot_err   (boot_err),
      .boot_words (boot_words)
   );

   always #5 clk = ~clk;

   // External synchronous single-port memory
   logic [31:0] mem     [DEPTH];
   logic [31:0] ref_mem [DEPTH];
   int          n_writes;

   always @(posedge clk) begin
      if (bus.mem_we) begin
         mem[bus.mem_addr] <= bus.mem_wdata;
         n_writes = n_writes + 1;
      end
      bus.mem_rdata <= mem[bus.mem_addr];
   end

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic [31:0] addr;
      logic        fault;
      logic [31:0] rdata;
   } fvec_t;

   fvec_t ftab [7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst           = 1'b1;
      bus.ld_valid  = 1'b0;
      bus.ld_last   = 1'b0;
      bus.ld_data   = 32'h0;
      bus.fetch_req = 1'b0;
      bus.fetch_addr = 32'h0;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic check_reset_state();
      chk("rst_core_rst",    32'(core_rst),        32'd1);
      chk("rst_boot_done",   32'(boot_done),       32'd0);
      chk("rst_boot_err",    32'(boot_err),        32'd0);
      chk("rst_boot_words",  32'(boot_words),      32'd0);
      chk("rst_fetch_valid", 32'(bus.fetch_valid), 32'd0);
      chk("rst_fetch_fault", 32'(bus.fetch_fault), 32'd0);
      chk("rst_fetch_rdata", bus.fetch_rdata,      32'd0);
      chk("rst_ld_ready",    32'(bus.ld_ready),    32'd1);
   endtask

   // One loader beat that must be accepted into word exp_addr
   task automatic send_word(input logic [31:0] d, input logic last, input int exp_addr);
      bus.ld_valid = 1'b1;
      bus.ld_data  = d;
      bus.ld_last  = last;
      @(negedge clk);
      chk("ld_ready",  32'(bus.ld_ready),  32'd1);
      chk("mem_we",    32'(bus.mem_we),    32'd1);
      chk("mem_addr",  32'(bus.mem_addr),  32'(exp_addr));
      chk("mem_wdata", bus.mem_wdata,      d);
      step();
      bus.ld_valid = 1'b0;
      bus.ld_last  = 1'b0;
      ref_mem[exp_addr] = d;
   endtask

   // Loader stall in LOAD: stray ld_last and fetch_req must do nothing
   task automatic idle_ld(input int n, input int ptr);
      for (int k = 0; k < n; k++) begin
         bus.ld_valid   = 1'b0;
         bus.ld_last    = 1'b1;
         bus.fetch_req  = 1'b1;
         bus.fetch_addr = 32'h0000_0010;
         @(negedge clk);
         chk("stall_mem_we",   32'(bus.mem_we),   32'd0);
         chk("stall_mem_addr", 32'(bus.mem_addr), 32'(ptr));
         step();
         chk("stall_fetch_valid", 32'(bus.fetch_valid), 32'd0);
      end
      bus.ld_last   = 1'b0;
      bus.fetch_req = 1'b0;
   endtask

   // Called in the cycle after the last accept: FLUSH, then RUN
   task automatic finish_load(input int n);
      bus.ld_valid   = 1'b1;
      bus.ld_data    = 32'hDEAD_BEEF;
      bus.fetch_req  = 1'b1;
      bus.fetch_addr = 32'h0;
      @(negedge clk);
      chk("flush_ld_ready",  32'(bus.ld_ready), 32'd0);
      chk("flush_mem_we",    32'(bus.mem_we),   32'd0);
      chk("flush_core_rst",  32'(core_rst),     32'd1);
      chk("flush_boot_done", 32'(boot_done),    32'd0);
      step();
      bus.fetch_req = 1'b0;
      chk("run_core_rst",    32'(core_rst),        32'd0);
      chk("run_boot_done",   32'(boot_done),       32'd1);
      chk("run_boot_err",    32'(boot_err),        32'd0);
      chk("run_boot_words",  32'(boot_words),      32'(n));
      chk("run_fetch_valid", 32'(bus.fetch_valid), 32'd0);
      @(negedge clk);
      chk("run_ld_ready", 32'(bus.ld_ready), 32'd0);
      chk("run_mem_we",   32'(bus.mem_we),   32'd0);
      step();
      bus.ld_valid = 1'b0;
   endtask

   task automatic apply_fetch_table();
      for (int i = 0; i < 7; i++) begin
         bus.fetch_req  = 1'b1;
         bus.fetch_addr = ftab[i].addr;
         step();
         chk($sformatf("tab_valid[%0d]", i), 32'(bus.fetch_valid), 32'd1);
         chk($sformatf("tab_fault[%0d]", i), 32'(bus.fetch_fault), 32'(ftab[i].fault));
         chk($sformatf("tab_rdata[%0d]", i), bus.fetch_rdata,      ftab[i].rdata);
      end
      bus.fetch_req = 1'b0;
      step();
      chk("tab_idle_valid", 32'(bus.fetch_valid), 32'd0);
      chk("tab_idle_hold",  bus.fetch_rdata,      ftab[6].rdata);
   endtask

   // Random fetch traffic; expected response computed from address rules
   task automatic random_fetches(input int cycles, input int img_len);
      logic [31:0] a;
      logic [31:0] last_rdata;
      logic        req;
      logic        exp_fault;
      logic [31:0] exp_rdata;
      last_rdata = 32'h0;
      for (int c = 0; c < cycles; c++) begin
         req = ($urandom_range(0, 3) != 0);
         case ($urandom_range(0, 5))
            0:       a = 32'($urandom_range(0, DEPTH - 1)) << 2;
            1:       a = (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
            2:       a = ($urandom & 32'hFFFF_FFFC) | 32'h0000_1000;
            default: a = 32'($urandom_range(0, img_len + 3)) << 2;
         endcase
         bus.fetch_req  = req;
         bus.fetch_addr = a;
         exp_fault = 1'b0;
         exp_rdata = last_rdata;
         if (req) begin
            exp_fault = ((a % 4) != 0) || (a >= 32'(DEPTH * 4));
            exp_rdata = exp_fault ? 32'h0 : ref_mem[a / 4];
            last_rdata = exp_rdata;
         end
         step();
         chk("rnd_valid", 32'(bus.fetch_valid), 32'(req));
         if (req) begin
            chk("rnd_fault", 32'(bus.fetch_fault), 32'(exp_fault));
         end
         chk("rnd_rdata", bus.fetch_rdata, exp_rdata);
      end
      bus.fetch_req = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int bad;

      for (int i = 0; i < int'(DEPTH); i++) begin
         mem[i]     = 32'h0;
         ref_mem[i] = 32'h0;
      end
      n_writes = 0;

      ftab[0] = '{addr: 32'h0000_0004, fault: 1'b0, rdata: 32'h00B6_2423};
      ftab[1] = '{addr: 32'h0000_0008, fault: 1'b0, rdata: 32'hFFC4_A303};
      ftab[2] = '{addr: 32'h0000_0006, fault: 1'b1, rdata: 32'h0};
      ftab[3] = '{addr: 32'h0000_1000, fault: 1'b1, rdata: 32'h0};
      ftab[4] = '{addr: 32'h0000_0FFC, fault: 1'b0, rdata: 32'h0};
      ftab[5] = '{addr: 32'h0000_0000, fault: 1'b0, rdata: 32'h0062_E233};
      ftab[6] = '{addr: 32'h0000_0008, fault: 1'b0, rdata: 32'hFFC4_A303};

      // T1: three-word image
      do_reset();
      check_reset_state();
      send_word(32'h0062_E233, 1'b0, 0);
      send_word(32'h00B6_2423, 1'b0, 1);
      send_word(32'hFFC4_A303, 1'b1, 2);
      finish_load(3);

      // T2/T3: fetch table incl. faults
      apply_fetch_table();

      // T6: stalling loader, one-word image
      do_reset();
      n_writes = 0;
      idle_ld(1, 0);
      send_word(32'h1234_5678, 1'b1, 0);
      finish_load(1);
      chk("t6_write_count", 32'(n_writes), 32'd1);
      bus.fetch_req  = 1'b1;
      bus.fetch_addr = 32'h0;
      step();
      bus.fetch_req = 1'b0;
      chk("t6_valid", 32'(bus.fetch_valid), 32'd1);
      chk("t6_fault", 32'(bus.fetch_fault), 32'd0);
      chk("t6_rdata", bus.fetch_rdata,      32'h1234_5678);

      // T5: reset in the middle of a load
      do_reset();
      for (int i = 0; i < 5; i++) begin
         send_word(32'hA500_0000 | 32'(i), 1'b0, i);
      end
      chk("t5_words_before", 32'(boot_words), 32'd5);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check_reset_state();
      send_word(32'h0BAD_F00D, 1'b1, 0);
      finish_load(1);

      // Randomized images and fetch traffic
      for (int it = 0; it < 8; it++) begin
         do_reset();
         n = $urandom_range(1, 48);
         for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 2) == 0) begin
               idle_ld($urandom_range(1, 3), i);
            end
            send_word($urandom, (i == n - 1), i);
         end
         finish_load(n);
         random_fetches(40, n);
      end

      // T4: overflow with no ld_last
      do_reset();
      for (int i = 0; i < int'(DEPTH); i++) begin
         send_word($urandom, 1'b0, i);
      end
      chk("t4_boot_err",   32'(boot_err),     32'd1);
      chk("t4_core_rst",   32'(core_rst),     32'd1);
      chk("t4_boot_done",  32'(boot_done),    32'd0);
      chk("t4_boot_words", 32'(boot_words),   32'(DEPTH));
      chk("t4_ld_ready",   32'(bus.ld_ready), 32'd0);
      for (int k = 0; k < 3; k++) begin
         bus.ld_valid   = 1'b1;
         bus.ld_data    = 32'hCAFE_0000;
         bus.fetch_req  = 1'b1;
         bus.fetch_addr = 32'h0000_0004;
         @(negedge clk);
         chk("t4_err_mem_we",   32'(bus.mem_we),   32'd0);
         chk("t4_err_ld_ready", 32'(bus.ld_ready), 32'd0);
         step();
         chk("t4_err_fetch_valid", 32'(bus.fetch_valid), 32'd0);
         chk("t4_err_words",       32'(boot_words),      32'(DEPTH));
         chk("t4_err_sticky",      32'(boot_err),        32'd1);
      end
      bus.ld_valid  = 1'b0;
      bus.fetch_req = 1'b0;
      bad = 0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         if (mem[i] !== ref_mem[i]) bad++;
      end
      chk("t4_image_bad_words", 32'(bad), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
